screen_region_iface: RTL

//   Responder side of the rectangle-draw handshake used by the draw_* client blocks.
//   - Accepts a start request carrying a rectangle; walks its pixels row-major.
//   - Presents each pixel's x/y and current framebuffer colour back to the client.
//   - Plots the client's returned colour; pulses done when the rectangle is finished.
//   - Sits between the draw_* client mux and the framebuffer/VGA plot port.

---
 rtl/screen_region_iface_pkg.sv | 14 +
 rtl/screen_region_iface_if.sv | 27 ++
 rtl/screen_region_iface_region_counter.sv | 73 +++++++
 rtl/screen_region_iface.sv | 127 ++++++++++++
 4 files changed

// File: rtl/screen_region_iface_pkg.sv
// Shared types and defaults for the rectangle-draw responder.
package screen_region_iface_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int SCREEN_SIZE_X_DEF = 160;
  localparam int SCREEN_SIZE_Y_DEF = 120;

endpackage

// File: rtl/screen_region_iface_if.sv
// Client <-> responder rectangle-draw handshake bundle.
interface screen_region_iface_if #(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3
);
  logic                    start;
  logic [WIDTH-1:0]        x_min;
  logic [WIDTH-1:0]        y_min;
  logic [WIDTH-1:0]        x_range;
  logic [WIDTH-1:0]        y_range;
  logic [COLOUR_WIDTH-1:0] new_colour;
  logic [WIDTH-1:0]        screen_x;
  logic [WIDTH-1:0]        screen_y;
  logic [COLOUR_WIDTH-1:0] old_colour;
  logic                    done;
  logic                    busy;

  modport master (
    output start, x_min, y_min, x_range, y_range, new_colour,
    input  screen_x, screen_y, old_colour, done, busy
  );

  modport slave (
    input  start, x_min, y_min, x_range, y_range, new_colour,
    output screen_x, screen_y, old_colour, done, busy
  );
endinterface

// File: rtl/screen_region_iface_region_counter.sv
// Loadable row-major x/y walker; positions and bounds kept one bit wider so
// rectangles running past the coordinate range never wrap.
module region_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] x_min,
  input  logic [WIDTH-1:0] y_min,
  input  logic [WIDTH-1:0] x_range,
  input  logic [WIDTH-1:0] y_range,
  output logic [WIDTH:0]   x,
  output logic [WIDTH:0]   y,
  output logic             last
);
  logic [WIDTH:0] x_q, x_d;
  logic [WIDTH:0] y_q, y_d;
  logic [WIDTH:0] x_org_q, x_org_d;
  logic [WIDTH:0] x_end_q, x_end_d;
  logic [WIDTH:0] y_end_q, y_end_d;
  logic [WIDTH:0] x_next;
  logic [WIDTH:0] y_next;
  logic           row_end;

  always_comb begin
    x_next  = x_q + {{WIDTH{1'b0}}, 1'b1};
    y_next  = y_q + {{WIDTH{1'b0}}, 1'b1};
    row_end = (x_next == x_end_q);
    last    = row_end && (y_next == y_end_q);
    x_d     = x_q;
    y_d     = y_q;
    x_org_d = x_org_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    if (load) begin
      x_d     = {1'b0, x_min};
      y_d     = {1'b0, y_min};
      x_org_d = {1'b0, x_min};
      x_end_d = {1'b0, x_min} + {1'b0, x_range};
      y_end_d = {1'b0, y_min} + {1'b0, y_range};
    end else if (advance) begin
      if (row_end) begin
        x_d = x_org_q;
        y_d = y_next;
      end else begin
        x_d = x_next;
      end
    end else begin
      x_d = x_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= {(WIDTH+1){1'b0}};
      y_q     <= {(WIDTH+1){1'b0}};
      x_org_q <= {(WIDTH+1){1'b0}};
      x_end_q <= {(WIDTH+1){1'b0}};
      y_end_q <= {(WIDTH+1){1'b0}};
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      x_org_q <= x_org_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
    end
  end

  assign x = x_q;
  assign y = y_q;
endmodule

// File: rtl/screen_region_iface.sv
// Responder for the rectangle-draw handshake: walks the rectangle, reads the
// framebuffer per pixel, and plots the colour the client returns.
module screen_region_iface
  import screen_region_iface_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int COLOUR_WIDTH  = 3,
  parameter int SCREEN_SIZE_X = SCREEN_SIZE_X_DEF,
  parameter int SCREEN_SIZE_Y = SCREEN_SIZE_Y_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  screen_region_iface_if.slave    bus,
  output logic [WIDTH-1:0]        fb_rd_x,
  output logic [WIDTH-1:0]        fb_rd_y,
  input  logic [COLOUR_WIDTH-1:0] fb_rd_data,
  output logic [WIDTH-1:0]        vga_x,
  output logic [WIDTH-1:0]        vga_y,
  output logic [COLOUR_WIDTH-1:0] vga_colour,
  output logic                    vga_plot
);
  localparam logic [WIDTH:0] X_LIMIT = (WIDTH+1)'(SCREEN_SIZE_X);
  localparam logic [WIDTH:0] Y_LIMIT = (WIDTH+1)'(SCREEN_SIZE_Y);

  state_e                  state_q, state_d;
  logic [WIDTH:0]          cnt_x, cnt_y;
  logic                    last_pixel;
  logic                    cnt_load, cnt_advance;
  logic                    zero_range, on_screen;
  logic [WIDTH-1:0]        vga_x_q, vga_x_d;
  logic [WIDTH-1:0]        vga_y_q, vga_y_d;
  logic [COLOUR_WIDTH-1:0] vga_colour_q, vga_colour_d;
  logic                    vga_plot_q, vga_plot_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  assign zero_range = (bus.x_range == {WIDTH{1'b0}}) || (bus.y_range == {WIDTH{1'b0}});
  assign on_screen  = (cnt_x < X_LIMIT) && (cnt_y < Y_LIMIT);

  region_counter #(.WIDTH(WIDTH)) u_region_counter (
    .clock   (clock),
    .reset   (reset),
    .load    (cnt_load),
    .advance (cnt_advance),
    .x_min   (bus.x_min),
    .y_min   (bus.y_min),
    .x_range (bus.x_range),
    .y_range (bus.y_range),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (last_pixel)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = zero_range ? S_DONE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = last_pixel ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The plot strobe lands one edge after S_WRITE, so the last plot and done coincide.
  always_comb begin
    cnt_load     = (state_q == S_IDLE) && bus.start && !zero_range;
    cnt_advance  = (state_q == S_WRITE) && !last_pixel;
    vga_plot_d   = (state_q == S_WRITE) && on_screen;
    vga_x_d      = {WIDTH{1'b0}};
    vga_y_d      = {WIDTH{1'b0}};
    vga_colour_d = {COLOUR_WIDTH{1'b0}};
    if (vga_plot_d) begin
      vga_x_d      = cnt_x[WIDTH-1:0];
      vga_y_d      = cnt_y[WIDTH-1:0];
      vga_colour_d = bus.new_colour;
    end else begin
      vga_colour_d = {COLOUR_WIDTH{1'b0}};
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vga_x_q      <= {WIDTH{1'b0}};
      vga_y_q      <= {WIDTH{1'b0}};
      vga_colour_q <= {COLOUR_WIDTH{1'b0}};
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.screen_x   = cnt_x[WIDTH-1:0];
  assign bus.screen_y   = cnt_y[WIDTH-1:0];
  assign bus.old_colour = (state_q == S_WRITE) ? fb_rd_data : {COLOUR_WIDTH{1'b0}};
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign fb_rd_x        = cnt_x[WIDTH-1:0];
  assign fb_rd_y        = cnt_y[WIDTH-1:0];
  assign vga_x          = vga_x_q;
  assign vga_y          = vga_y_q;
  assign vga_colour     = vga_colour_q;
  assign vga_plot       = vga_plot_q;
endmodule
